// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and forwarding controller for the in-order MIPS pipeline.
// Tracks in-flight destination registers through DEPTH post-EX stages, each entry
// carrying the stage index at which its result becomes available. Produces the ID
// stall/bubble controls and the EX operand forwarding selects.
//
// Optional feature: define STALL_CNT_EN to build a saturating 32-bit stall-cycle
// counter on stall_cnt; when undefined there are no counter flops and stall_cnt is 0.
module pipe_hazard_ctrl #(
    parameter int RADDR_W = 5,
    parameter int DEPTH   = 2,
    parameter int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               hold,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic               id_use_rs,
    input  logic               id_use_rt,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_regwrite,
    input  logic [SEL_W-1:0]   id_ready,
    output logic               stall,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               bubble,
    output logic [SEL_W-1:0]   fwd_a,
    output logic [SEL_W-1:0]   fwd_b,
    output logic [31:0]        stall_cnt
);

    // One tracked instruction: does it write a register, which one, and the
    // stage index whose output register first holds the result.
    typedef struct packed {
        logic               valid;
        logic [RADDR_W-1:0] dst;
        logic [SEL_W-1:0]   rdy;
    } trk_t;

    // trk_q[0] is the instruction in EX, trk_q[k] the output of stage k.
    trk_t               trk_q [DEPTH+1];
    logic [RADDR_W-1:0] ex_rs_q;
    logic [RADDR_W-1:0] ex_rt_q;

    logic [SEL_W-1:0]   id_rdy_c;
    trk_t               id_entry;
    logic               haz_a;
    logic               haz_b;
    logic               hit_a;
    logic               hit_b;
    logic               fhit_a;
    logic               fhit_b;
    logic               accept;

    // Clamp the producer's ready stage into 1..DEPTH.
    // NOTE: every combinational output gets a default first so no path through
    // the block leaves it unassigned; that is what keeps latches from inferring.
    always_comb begin
        id_rdy_c = id_ready;
        if (id_ready == '0) begin
            id_rdy_c = SEL_W'(1);
        end else if (int'(id_ready) > DEPTH) begin
            id_rdy_c = SEL_W'(DEPTH);
        end
    end

    // Tracker entry for the ID instruction; writes of r0 or non-writers are stored invalid.
    always_comb begin
        id_entry.valid = id_regwrite && (id_rd != '0);
        id_entry.dst   = id_rd;
        id_entry.rdy   = id_rdy_c;
    end

    // Load-use detection: the youngest matching producer decides, older ones are shadowed.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!hit_a && id_use_rs && (id_rs != '0) &&
                trk_q[k].valid && (trk_q[k].dst == id_rs)) begin
                hit_a = 1'b1;
                haz_a = (int'(trk_q[k].rdy) > k + 1);
            end
            if (!hit_b && id_use_rt && (id_rt != '0) &&
                trk_q[k].valid && (trk_q[k].dst == id_rt)) begin
                hit_b = 1'b1;
                haz_b = (int'(trk_q[k].rdy) > k + 1);
            end
        end
    end

    // ID-stage control: a flushed or empty slot never stalls; hold freezes everything.
    always_comb begin
        stall      = id_valid && !flush && (haz_a || haz_b);
        pc_write   = !stall && !hold;
        ifid_write = !stall && !hold;
        bubble     = (stall || flush) && !hold;
        accept     = id_valid && !stall && !flush;
    end

    // EX forwarding: pick the youngest post-EX producer of each EX operand, if its result exists.
    always_comb begin
        fhit_a = 1'b0;
        fhit_b = 1'b0;
        fwd_a  = '0;
        fwd_b  = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (!fhit_a && (ex_rs_q != '0) &&
                trk_q[k].valid && (trk_q[k].dst == ex_rs_q)) begin
                fhit_a = 1'b1;
                if (int'(trk_q[k].rdy) <= k) begin
                    fwd_a = SEL_W'(k);
                end
            end
            if (!fhit_b && (ex_rt_q != '0) &&
                trk_q[k].valid && (trk_q[k].dst == ex_rt_q)) begin
                fhit_b = 1'b1;
                if (int'(trk_q[k].rdy) <= k) begin
                    fwd_b = SEL_W'(k);
                end
            end
        end
    end

    // Tracker advance: shift one stage per unheld edge, EX slot gets the ID instruction or a bubble.
    // NOTE: sequential state uses non-blocking assignments so the shift reads every
    // entry's old value; blocking here would ripple one entry through the whole chain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // The tracker is a handful of flops whose valid bits gate every
            // hazard decision, so all entries clear on reset.
            for (int k = 0; k <= DEPTH; k++) begin
                trk_q[k] <= '0;
            end
            ex_rs_q <= '0;
            ex_rt_q <= '0;
        end else if (!hold) begin
            for (int k = 0; k < DEPTH; k++) begin
                trk_q[k+1] <= trk_q[k];
            end
            if (accept) begin
                trk_q[0] <= id_entry;
                ex_rs_q  <= id_use_rs ? id_rs : '0;
                ex_rt_q  <= id_use_rt ? id_rt : '0;
            end else begin
                trk_q[0] <= '0;
                ex_rs_q  <= '0;
                ex_rt_q  <= '0;
            end
        end
    end

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of edges on which ID was held back by a hazard.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall && !hold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a DEPTH=2 and a DEPTH=4 instance share stimulus.
module tb_pipe_hazard_ctrl;

    logic        clock;
    logic        reset;
    logic        hold;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic [2:0]  rdy_v;

    logic        stall2, pc_write2, ifid_write2, bubble2;
    logic [1:0]  fwd_a2, fwd_b2;
    logic [31:0] stall_cnt2;
    logic        stall4, pc_write4, ifid_write4, bubble4;
    logic [2:0]  fwd_a4, fwd_b4;
    logic [31:0] stall_cnt4;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    pipe_hazard_ctrl #(.RADDR_W(5), .DEPTH(2)) u2 (
        .clock(clock), .reset(reset), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_ready(rdy_v[1:0]),
        .stall(stall2), .pc_write(pc_write2), .ifid_write(ifid_write2),
        .bubble(bubble2), .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall_cnt(stall_cnt2)
    );

    pipe_hazard_ctrl #(.RADDR_W(5), .DEPTH(4)) u4 (
        .clock(clock), .reset(reset), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_ready(rdy_v),
        .stall(stall4), .pc_write(pc_write4), .ifid_write(ifid_write4),
        .bubble(bubble4), .fwd_a(fwd_a4), .fwd_b(fwd_b4), .stall_cnt(stall_cnt4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected counter value depends on whether the counter is built.
    task automatic check_cnt(input string tag);
`ifdef STALL_CNT_EN
        check(tag, stall_cnt2, 32'(exp_cnt));
`else
        check(tag, stall_cnt2, 32'h0);
`endif
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic op(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                      input logic urt, input logic [4:0] rd, input logic rw,
                      input logic [2:0] rdy);
        id_valid    = 1'b1;
        id_rs       = rs;
        id_use_rs   = urs;
        id_rt       = rt;
        id_use_rt   = urt;
        id_rd       = rd;
        id_regwrite = rw;
        rdy_v       = rdy;
        #1;
    endtask

    task automatic idle();
        id_valid    = 1'b0;
        id_use_rs   = 1'b0;
        id_use_rt   = 1'b0;
        id_regwrite = 1'b0;
        id_rs       = '0;
        id_rt       = '0;
        id_rd       = '0;
        rdy_v       = '0;
        #1;
    endtask

    task automatic drain(input int n);
        idle();
        repeat (n) tick();
    endtask

    initial begin
        reset = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        idle();
        #10;
        check("rst_stall", stall2, 0);
        check("rst_fwd_a", fwd_a2, 0);
        check("rst_fwd_b", fwd_b2, 0);
        check("rst_pc_write", pc_write2, 1);
        check("rst_ifid_write", ifid_write2, 1);
        check("rst_bubble", bubble2, 0);
        check_cnt("rst_cnt");
        @(negedge clock);
        reset = 1'b1;
        tick();

        // ALU chain: add r3 ; sub r6 <- r3 ; or r7 <- r3
        op(5'd1, 1, 5'd2, 1, 5'd3, 1, 3'd1);
        check("alu_prod_stall", stall2, 0);
        tick();
        op(5'd3, 1, 5'd2, 1, 5'd6, 1, 3'd1);
        check("alu_cons_stall", stall2, 0);
        tick();
        op(5'd3, 1, 5'd0, 0, 5'd7, 1, 3'd1);
        check("alu_fwd_a1", fwd_a2, 1);
        check("alu_fwd_b0", fwd_b2, 0);
        check("alu_next_stall", stall2, 0);
        tick();
        idle();
        check("alu_fwd_a2", fwd_a2, 2);
        drain(3);

        // Load-use: lw r5 ; add r8 <- r2, r5
        op(5'd1, 1, 5'd0, 0, 5'd5, 1, 3'd2);
        tick();
        op(5'd2, 1, 5'd5, 1, 5'd8, 1, 3'd1);
        check("lu_stall", stall2, 1);
        check("lu_bubble", bubble2, 1);
        check("lu_pc_write", pc_write2, 0);
        check("lu_ifid_write", ifid_write2, 0);
        exp_cnt++;
        tick();
        check("lu_stall_gone", stall2, 0);
        check("lu_bubble_gone", bubble2, 0);
        check("lu_pc_write_back", pc_write2, 1);
        tick();
        idle();
        check("lu_fwd_b2", fwd_b2, 2);
        check("lu_fwd_a0", fwd_a2, 0);
        check_cnt("lu_cnt");
        drain(3);

        // Youngest wins: two writers of r4, then a reader
        op(5'd1, 1, 5'd0, 0, 5'd4, 1, 3'd1);
        tick();
        op(5'd1, 1, 5'd0, 0, 5'd4, 1, 3'd1);
        tick();
        op(5'd4, 1, 5'd0, 0, 5'd9, 1, 3'd1);
        check("yw_stall", stall2, 0);
        tick();
        idle();
        check("yw_fwd_a1", fwd_a2, 1);
        drain(3);

        // r0 writes never stall or forward
        op(5'd1, 1, 5'd0, 0, 5'd0, 1, 3'd2);
        tick();
        op(5'd0, 1, 5'd0, 1, 5'd9, 1, 3'd1);
        check("r0_stall", stall2, 0);
        tick();
        idle();
        check("r0_fwd_a", fwd_a2, 0);
        check("r0_fwd_b", fwd_b2, 0);
        drain(3);

        // hold during a load-use stall
        op(5'd1, 1, 5'd0, 0, 5'd5, 1, 3'd2);
        tick();
        op(5'd2, 1, 5'd5, 1, 5'd8, 1, 3'd1);
        check("hold_pre_stall", stall2, 1);
        hold = 1'b1;
        #1;
        check("hold_pc_write", pc_write2, 0);
        check("hold_bubble", bubble2, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_frozen_stall", stall2, 1);
        end
        check_cnt("hold_cnt_frozen");
        hold = 1'b0;
        #1;
        check("hold_release_stall", stall2, 1);
        exp_cnt++;
        tick();
        check("hold_one_stall", stall2, 0);
        check_cnt("hold_cnt");
        tick();
        idle();
        check("hold_fwd_b2", fwd_b2, 2);
        drain(3);

        // flush kills a pending load-use consumer, which then never enters EX
        op(5'd1, 1, 5'd0, 0, 5'd5, 1, 3'd2);
        tick();
        op(5'd2, 1, 5'd5, 1, 5'd9, 1, 3'd2);
        flush = 1'b1;
        #1;
        check("flush_stall", stall2, 0);
        check("flush_bubble", bubble2, 1);
        check("flush_pc_write", pc_write2, 1);
        tick();
        flush = 1'b0;
        op(5'd9, 1, 5'd0, 0, 5'd10, 1, 3'd1);
        check("flush_t0_bubble", stall2, 0);
        tick();
        idle();
        check("flush_no_fwd", fwd_a2, 0);
        check_cnt("flush_cnt");
        drain(3);

        // id_ready clamp: 0 behaves as 1
        op(5'd1, 1, 5'd0, 0, 5'd11, 1, 3'd0);
        tick();
        op(5'd11, 1, 5'd0, 0, 5'd12, 1, 3'd1);
        check("clamp0_stall", stall2, 0);
        tick();
        idle();
        check("clamp0_fwd_a1", fwd_a2, 1);
        drain(3);

        // id_ready clamp: 3 on DEPTH=2 behaves as 2
        op(5'd1, 1, 5'd0, 0, 5'd13, 1, 3'd3);
        tick();
        op(5'd13, 1, 5'd0, 0, 5'd14, 1, 3'd1);
        check("clamp3_stall", stall2, 1);
        exp_cnt++;
        tick();
        check("clamp3_stall_gone", stall2, 0);
        tick();
        idle();
        check("clamp3_fwd_a2", fwd_a2, 2);
        check_cnt("clamp3_cnt");
        drain(3);

        // reset asserted mid-stall
        op(5'd1, 1, 5'd0, 0, 5'd5, 1, 3'd2);
        tick();
        op(5'd2, 1, 5'd5, 1, 5'd8, 1, 3'd1);
        check("rms_pre_stall", stall2, 1);
        reset = 1'b0;
        #1;
        check("rms_stall_drop", stall2, 0);
        exp_cnt = 0;
        check_cnt("rms_cnt");
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("rms_after_stall", stall2, 0);
        drain(5);

        // DEPTH=4 with a rdy=4 producer: three stalls then forward from stage 4
        op(5'd1, 1, 5'd0, 0, 5'd10, 1, 3'd4);
        tick();
        op(5'd10, 1, 5'd0, 0, 5'd14, 1, 3'd1);
        for (int i = 0; i < 3; i++) begin
            check("d4_stall", stall4, 1);
            tick();
        end
        check("d4_stall_gone", stall4, 0);
        tick();
        idle();
        check("d4_fwd_a4", fwd_a4, 4);
        drain(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
